// File: rtl/gumnut_port_pkg.sv
// Shared constants and types for Gumnut I/O port peripherals.
// Register offsets and control-bit positions of the port timer.
package gumnut_port_pkg;

    typedef logic [7:0] port_word_t;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_RLD_LO = 3'd2;
    localparam logic [2:0] OFF_RLD_HI = 3'd3;
    localparam logic [2:0] OFF_CNT_LO = 3'd4;
    localparam logic [2:0] OFF_CNT_HI = 3'd5;
    localparam logic [2:0] OFF_PRESC  = 3'd6;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

endpackage

// File: rtl/gumnut_port_if.sv
// Gumnut I/O port bus: core (master) to peripheral (slave).
interface gumnut_port_if;
    import gumnut_port_pkg::*;

    logic       port_cyc_i;
    logic       port_stb_i;
    logic       port_we_i;
    port_word_t port_adr_i;
    port_word_t port_dat_i;
    logic       port_ack_o;
    port_word_t port_dat_o;

    modport master (
        output port_cyc_i, port_stb_i, port_we_i,
        output port_adr_i, port_dat_i,
        input  port_ack_o, port_dat_o
    );

    modport slave (
        input  port_cyc_i, port_stb_i, port_we_i,
        input  port_adr_i, port_dat_i,
        output port_ack_o, port_dat_o
    );

endinterface

// File: rtl/gumnut_port_slave.sv
// Reusable port-bus slave: 8-word decode, one-cycle ack pulse,
// registered read data that is zero whenever ack is low.
module gumnut_port_slave
    import gumnut_port_pkg::*;
#(
    parameter port_word_t BASE_ADDR = 8'h10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    gumnut_port_if.slave bus,
    input  port_word_t   rd_data,
    output logic [2:0]   off,
    output logic         wr_en,
    output logic         rd_en,
    output port_word_t   wr_data
);

    logic       sel;
    logic       acc;
    logic       ack_q;
    port_word_t dat_q;

    assign sel = bus.port_cyc_i & bus.port_stb_i
               & (bus.port_adr_i[7:3] == BASE_ADDR[7:3]);

    // A held strobe must not produce a second access on the ack cycle.
    assign acc     = sel & ~ack_q;
    assign wr_en   = acc & bus.port_we_i;
    assign rd_en   = acc & ~bus.port_we_i;
    assign off     = bus.port_adr_i[2:0];
    assign wr_data = bus.port_dat_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= rd_en ? rd_data : '0;
        end
    end

    assign bus.port_ack_o = ack_q;
    assign bus.port_dat_o = dat_q;

endmodule

// File: rtl/gumnut_port_timer.sv
// 16-bit interval timer with 8-bit prescaler on the Gumnut port bus.
// Expiry raises int_req_o when enabled; int_ack_i or W1C clears it.
module gumnut_port_timer
    import gumnut_port_pkg::*;
#(
    parameter port_word_t BASE_ADDR = 8'h10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    gumnut_port_if.slave bus,
    output logic         int_req_o,
    input  logic         int_ack_i
);

    logic [2:0]  off;
    logic        wr_en;
    logic        rd_en;
    port_word_t  wr_data;
    port_word_t  rd_data;

    logic        en;
    logic        auto_rld;
    logic        ie;
    logic        exp_q;
    logic [15:0] reload;
    logic [15:0] count;
    port_word_t  rld_lo;
    port_word_t  cnt_hi_sh;
    port_word_t  presc;
    port_word_t  psc_cnt;

    logic wr_ctrl, wr_status, wr_rlo, wr_rhi, wr_presc;
    logic rd_clo, psc_wrap, tick, expire;

    gumnut_port_slave #(
        .BASE_ADDR(BASE_ADDR)
    ) u_slave (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus),
        .rd_data(rd_data),
        .off    (off),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_data(wr_data)
    );

    assign wr_ctrl   = wr_en & (off == OFF_CTRL);
    assign wr_status = wr_en & (off == OFF_STATUS);
    assign wr_rlo    = wr_en & (off == OFF_RLD_LO);
    assign wr_rhi    = wr_en & (off == OFF_RLD_HI);
    assign wr_presc  = wr_en & (off == OFF_PRESC);
    assign rd_clo    = rd_en & (off == OFF_CNT_LO);

    // A RELOAD_HI write swallows a coincident tick.
    assign psc_wrap = en & (psc_cnt == presc);
    assign tick     = psc_wrap & ~wr_rhi;
    assign expire   = tick & (count == 16'd0);

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:   rd_data = {5'd0, ie, auto_rld, en};
            OFF_STATUS: rd_data = {7'd0, exp_q};
            OFF_RLD_LO: rd_data = rld_lo;
            OFF_RLD_HI: rd_data = reload[15:8];
            OFF_CNT_LO: rd_data = count[7:0];
            OFF_CNT_HI: rd_data = cnt_hi_sh;
            OFF_PRESC:  rd_data = presc;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en       <= 1'b0;
            auto_rld <= 1'b0;
            ie       <= 1'b0;
        end else if (wr_ctrl) begin
            en       <= wr_data[CTRL_EN];
            auto_rld <= wr_data[CTRL_AUTO];
            ie       <= wr_data[CTRL_IE];
        end else if (expire && !auto_rld) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exp_q     <= 1'b0;
            int_req_o <= 1'b0;
        end else begin
            if (expire)
                exp_q <= 1'b1;
            else if (int_ack_i || (wr_status && wr_data[0]))
                exp_q <= 1'b0;
            int_req_o <= exp_q & ie;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rld_lo    <= '0;
            reload    <= '0;
            presc     <= '0;
            cnt_hi_sh <= '0;
        end else begin
            if (wr_rlo)
                rld_lo <= wr_data;
            if (wr_rhi)
                reload <= {wr_data, rld_lo};
            if (wr_presc)
                presc <= wr_data;
            if (rd_clo)
                cnt_hi_sh <= count[15:8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            psc_cnt <= '0;
            count   <= '0;
        end else begin
            if (wr_rhi)
                psc_cnt <= '0;
            else if (en)
                psc_cnt <= psc_wrap ? 8'd0 : psc_cnt + 8'd1;

            if (wr_rhi)
                count <= {wr_data, rld_lo};
            else if (tick && count != 16'd0)
                count <= count - 16'd1;
            else if (expire && auto_rld)
                count <= reload;
        end
    end

endmodule

// File: tb/tb_gumnut_port_timer.sv
// Randomized bench for gumnut_port_timer against an arithmetic
// model of tick count, expiry and reload derived from edge numbers.
module tb_gumnut_port_timer;
    import gumnut_port_pkg::*;

    localparam port_word_t BASE = 8'h10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        int_ack_i = 1'b0;
    logic        int_req_o;
    int unsigned edge_n = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    gumnut_port_if bus_if ();

    gumnut_port_timer #(
        .BASE_ADDR(BASE)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bus      (bus_if),
        .int_req_o(int_req_o),
        .int_ack_i(int_ack_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_n <= edge_n + 1;

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus(input bit we, input port_word_t adr,
                       input port_word_t wd, input bit exp_ack,
                       output port_word_t rd, output int unsigned ae);
        bus_if.port_cyc_i = 1'b1;
        bus_if.port_stb_i = 1'b1;
        bus_if.port_we_i  = we;
        bus_if.port_adr_i = adr;
        bus_if.port_dat_i = wd;
        ae = edge_n + 1;
        @(negedge clk_i);
        chk($sformatf("ack %02h", adr), 16'(bus_if.port_ack_o),
            16'(exp_ack));
        rd = bus_if.port_dat_o;
        if (!exp_ack)
            chk($sformatf("dat %02h", adr), 16'(rd), 16'h0);
        bus_if.port_cyc_i = 1'b0;
        bus_if.port_stb_i = 1'b0;
        bus_if.port_we_i  = 1'b0;
        @(negedge clk_i);
        chk("ack pulse", 16'(bus_if.port_ack_o), 16'h0);
    endtask

    task automatic wr_reg(input logic [2:0] off, input port_word_t d);
        port_word_t v;
        int unsigned ae;
        bus(1'b1, {BASE[7:3], off}, d, 1'b1, v, ae);
    endtask

    task automatic rd_reg(input logic [2:0] off, output port_word_t v,
                          output int unsigned ae);
        bus(1'b0, {BASE[7:3], off}, 8'h00, 1'b1, v, ae);
    endtask

    // Ticks seen before access edge s, counting from enable edge e0.
    function automatic int unsigned ticks(input int unsigned e0,
                                          input int unsigned s,
                                          input port_word_t p);
        return (s - 1 - e0) / (32'(p) + 1);
    endfunction

    function automatic logic [15:0] exp_count(input logic [15:0] r,
                                              input bit au,
                                              input int unsigned t);
        int unsigned rr = 32'(r);
        if (au)
            return 16'(rr - (t % (rr + 1)));
        return (t >= rr) ? 16'h0 : 16'(rr - t);
    endfunction

    task automatic arm(input logic [15:0] r, input port_word_t p,
                       input bit au, input bit ie,
                       output int unsigned e0);
        port_word_t v;
        wr_reg(OFF_CTRL, 8'h00);
        wr_reg(OFF_STATUS, 8'h01);
        wr_reg(OFF_PRESC, p);
        wr_reg(OFF_RLD_LO, r[7:0]);
        wr_reg(OFF_RLD_HI, r[15:8]);
        bus(1'b1, {BASE[7:3], OFF_CTRL}, {5'd0, ie, au, 1'b1},
            1'b1, v, e0);
    endtask

    task automatic trial(input logic [15:0] r, input port_word_t p,
                         input bit au, input bit ie,
                         input int unsigned d);
        port_word_t  lo, hi, v;
        int unsigned e0, s, x, t;
        arm(r, p, au, ie, e0);
        repeat (d) @(negedge clk_i);
        t = (edge_n - 1 - e0) / (32'(p) + 1);
        chk("int_req", 16'(int_req_o), 16'(ie && (t > 32'(r))));
        rd_reg(OFF_CNT_LO, lo, s);
        rd_reg(OFF_CNT_HI, hi, x);
        chk("count", {hi, lo}, exp_count(r, au, ticks(e0, s, p)));
        rd_reg(OFF_STATUS, v, s);
        chk("status", 16'(v), 16'(ticks(e0, s, p) > 32'(r)));
        rd_reg(OFF_CTRL, v, s);
        t = ticks(e0, s, p);
        chk("ctrl", 16'(v), {13'd0, ie, au, au || t <= 32'(r)});
        rd_reg(OFF_RLD_LO, v, s);
        chk("rld_lo", 16'(v), 16'(r[7:0]));
        rd_reg(OFF_RLD_HI, v, s);
        chk("rld_hi", 16'(v), 16'(r[15:8]));
        rd_reg(OFF_PRESC, v, s);
        chk("presc", 16'(v), 16'(p));
    endtask

    task automatic irq_tests();
        port_word_t  v;
        int unsigned e0, s;
        arm(16'd3, 8'd0, 1'b1, 1'b1, e0);
        while (edge_n < e0 + 5) @(negedge clk_i);
        chk("irq set", 16'(int_req_o), 16'h1);
        int_ack_i = 1'b1;
        @(negedge clk_i);
        int_ack_i = 1'b0;
        @(negedge clk_i);
        chk("irq ack clr", 16'(int_req_o), 16'h0);
        // Acknowledge lands on the next expiry edge (e0 + 8).
        int_ack_i = 1'b1;
        @(negedge clk_i);
        int_ack_i = 1'b0;
        chk("irq pre", 16'(int_req_o), 16'h0);
        @(negedge clk_i);
        chk("irq collide", 16'(int_req_o), 16'h1);
        wr_reg(OFF_CTRL, 8'h06);
        wr_reg(OFF_STATUS, 8'h00);
        rd_reg(OFF_STATUS, v, s);
        chk("w1c zero", 16'(v), 16'h1);
        chk("irq hold", 16'(int_req_o), 16'h1);
        wr_reg(OFF_STATUS, 8'h01);
        rd_reg(OFF_STATUS, v, s);
        chk("w1c one", 16'(v), 16'h0);
        chk("irq w1c", 16'(int_req_o), 16'h0);
    endtask

    initial begin
        port_word_t  v;
        int unsigned ae;
        bus_if.port_cyc_i = 1'b0;
        bus_if.port_stb_i = 1'b0;
        bus_if.port_we_i  = 1'b0;
        bus_if.port_adr_i = '0;
        bus_if.port_dat_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst ack", 16'(bus_if.port_ack_o), 16'h0);
        chk("rst irq", 16'(int_req_o), 16'h0);
        rst_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) begin
            rd_reg(3'(i), v, ae);
            chk($sformatf("reset rd %0d", i), 16'(v), 16'h0);
        end
        bus(1'b0, 8'h18, 8'h00, 1'b0, v, ae);
        bus(1'b0, 8'h0f, 8'h00, 1'b0, v, ae);
        bus(1'b1, 8'h18, 8'h55, 1'b0, v, ae);
        wr_reg(3'd7, 8'hff);
        rd_reg(3'd7, v, ae);
        chk("reserved", 16'(v), 16'h0);

        trial(16'd3, 8'd0, 1'b1, 1'b1, 0);
        trial(16'd3, 8'd0, 1'b1, 1'b1, 5);
        trial(16'd2, 8'd1, 1'b0, 1'b1, 10);
        trial(16'h0101, 8'd0, 1'b1, 1'b1, 0);
        wr_reg(OFF_CNT_LO, 8'haa);
        irq_tests();

        for (int i = 0; i < 24; i++) begin
            logic [15:0] r;
            r = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0)
                r[15:8] = 8'($urandom_range(1, 3));
            trial(r, 8'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 80));
        end

        bus_if.port_cyc_i = 1'b1;
        bus_if.port_stb_i = 1'b1;
        bus_if.port_adr_i = BASE;
        @(posedge clk_i);
        #1;
        chk("mid ack", 16'(bus_if.port_ack_o), 16'h1);
        rst_i = 1'b0;
        #1;
        chk("mid rst ack", 16'(bus_if.port_ack_o), 16'h0);
        chk("mid rst irq", 16'(int_req_o), 16'h0);
        bus_if.port_cyc_i = 1'b0;
        bus_if.port_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
